// File: rtl/key_index_ctrl.sv
// ============================================================================
// Module      : key_index_ctrl
// Description : Two-key (up/down) index controller. Each raw key is
//               synchronised and debounced, then drives a press/hold/repeat
//               state machine. Step requests move a bounded index that either
//               wraps or saturates at its limits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_index_ctrl #(
   parameter int ADDR_W   = 5,
   parameter int MIN_IDX  = 0,
   parameter int MAX_IDX  = 31,
   parameter int INIT_IDX = 0,
   parameter int WRAP     = 1,
   parameter int DB_CYC   = 1000000,
   parameter int HOLD_CYC = 25000000,
   parameter int REP_CYC  = 5000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              key_up,
   input  logic              key_dn,
   input  logic              clr,
   output logic [ADDR_W-1:0] idx,
   output logic              step,
   output logic              at_min,
   output logic              at_max
);

   // Counter sizing: the debounce counter tops out at DB_CYC-1, the
   // hold/repeat timer at max(HOLD_CYC, REP_CYC)-1.
   localparam int TM_MAX = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
   localparam int DB_W   = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
   localparam int TM_W   = (TM_MAX > 1) ? $clog2(TM_MAX) : 1;

   localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DB_CYC - 1);
   localparam logic [DB_W-1:0] DB_ONE    = DB_W'(1);
   localparam logic [TM_W-1:0] HOLD_LAST = TM_W'(HOLD_CYC - 1);
   localparam logic [TM_W-1:0] REP_LAST  = TM_W'(REP_CYC - 1);
   localparam logic [TM_W-1:0] TM_ONE    = TM_W'(1);
   localparam logic [TM_W-1:0] TM_ZERO   = '0;

   // Index arithmetic is carried one bit wider than idx.
   localparam logic [ADDR_W:0] MIN_V  = (ADDR_W + 1)'(MIN_IDX);
   localparam logic [ADDR_W:0] MAX_V  = (ADDR_W + 1)'(MAX_IDX);
   localparam logic [ADDR_W:0] INIT_V = (ADDR_W + 1)'(INIT_IDX);
   localparam logic [ADDR_W:0] ONE_V  = (ADDR_W + 1)'(1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_HOLD   = 2'd1,
      S_REPEAT = 2'd2
   } rep_state_t;

   // Bit 0 = up key, bit 1 = down key.
   logic [1:0] raw;
   logic [1:0] db_next;
   logic [1:0] press;
   logic [1:0] req;
   logic [1:0] warm;
   logic       lock;
   logic       lock_next;
   logic       both_low_next;
   logic       both_high_next;

   assign raw = {key_dn, key_up};

   // Once both keys are seen low together, every key stays locked out until
   // both have been released; only a fresh press after that counts.
   assign both_low_next  = ~db_next[0] & ~db_next[1];
   assign both_high_next =  db_next[0] &  db_next[1];
   assign lock_next      = both_low_next | (lock & ~both_high_next);

   // Track the both-keys lockout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lock <= 1'b0;
      else        lock <= lock_next;
   end

   // Synchroniser warm-up: the sync chains hold their reset value for two
   // edges, so their output is not trusted as a real key level until then.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) warm <= 2'b00;
      else        warm <= {warm[0], 1'b1};
   end

   for (genvar k = 0; k < 2; k++) begin : g_key
      logic            s1;
      logic            s2;
      logic            db;
      logic            differ;
      logic            armed;
      logic            req_r;
      logic [DB_W-1:0] db_cnt;
      logic [TM_W-1:0] tmr;
      rep_state_t      state;

      // A key must be stable for DB_CYC cycles; the level flips on the
      // cycle the counter would reach DB_CYC.
      assign differ     = (s2 != db);
      assign db_next[k] = (differ && (db_cnt == DB_LAST)) ? s2 : db;
      assign press[k]   = db & ~db_next[k];
      assign req[k]     = req_r;

      // Two-flop synchroniser for the raw asynchronous key.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
         end else begin
            s1 <= raw[k];
            s2 <= s1;
         end
      end

      // Debouncer: count consecutive cycles of disagreement with db.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            db     <= 1'b1;
            db_cnt <= '0;
         end else if (!differ) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            db     <= s2;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + DB_ONE;
         end
      end

      // Arm the key once it is genuinely seen released after reset, so a
      // key held through reset cannot generate steps until re-pressed.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)                    armed <= 1'b0;
         else if (warm[1] && s2 && db)  armed <= 1'b1;
      end

      // Press / hold / auto-repeat state machine with registered request.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state <= S_IDLE;
            tmr   <= '0;
            req_r <= 1'b0;
         end else begin
            req_r <= 1'b0;
            tmr   <= tmr + TM_ONE;
            if (lock_next || db_next[k]) begin
               state <= S_IDLE;
               tmr   <= TM_ZERO;
            end else begin
               case (state)
                  S_IDLE: begin
                     tmr <= TM_ZERO;
                     if (press[k] && armed) begin
                        state <= S_HOLD;
                        req_r <= 1'b1;
                     end
                  end
                  S_HOLD: begin
                     if (tmr == HOLD_LAST) begin
                        state <= S_REPEAT;
                        tmr   <= TM_ZERO;
                        req_r <= 1'b1;
                     end
                  end
                  S_REPEAT: begin
                     if (tmr == REP_LAST) begin
                        tmr   <= TM_ZERO;
                        req_r <= 1'b1;
                     end
                  end
                  default: begin
                     state <= S_IDLE;
                     tmr   <= TM_ZERO;
                  end
               endcase
            end
         end
      end
   end

   logic [ADDR_W:0] cur;
   logic [ADDR_W:0] nxt;

   assign cur = {1'b0, idx};

   // Next index: clear wins, opposing requests cancel, bounds wrap or hold.
   always_comb begin
      nxt = cur;
      if (clr) begin
         nxt = INIT_V;
      end else if (req[0] && !req[1]) begin
         if (cur == MAX_V) nxt = (WRAP != 0) ? MIN_V : cur;
         else              nxt = cur + ONE_V;
      end else if (req[1] && !req[0]) begin
         if (cur == MIN_V) nxt = (WRAP != 0) ? MAX_V : cur;
         else              nxt = cur - ONE_V;
      end
   end

   // Register index, change pulse and bound flags together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx    <= INIT_V[ADDR_W-1:0];
         step   <= 1'b0;
         at_min <= (INIT_IDX == MIN_IDX);
         at_max <= (INIT_IDX == MAX_IDX);
      end else begin
         idx    <= nxt[ADDR_W-1:0];
         step   <= (nxt != cur);
         at_min <= (nxt == MIN_V);
         at_max <= (nxt == MAX_V);
      end
   end

endmodule

`default_nettype wire
